uart_rx_fifo_ctrl: RTL

//  Receive-side buffer controller between the UART RX engine and the APB register file.

---
 rtl/uart_rx_fifo_ctrl_if.sv | 35 +++
 rtl/uart_rx_fifo_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_ctrl_if.sv
// Bus bundle between the UART RX engine / CPU register side (master) and the
// receive FIFO controller (slave). Widths of LEVEL and RX_THRESH follow DEPTH_LOG2.
interface uart_rx_fifo_ctrl_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic                  BAUD_TICK;
  logic                  RX_STROBE;
  logic [7:0]            RX_DATA;
  logic                  RX_PERR;
  logic                  RX_FERR;
  logic                  RD_EN;
  logic                  CLR_ERR;
  logic [DEPTH_LOG2:0]   RX_THRESH;
  logic [7:0]            RD_DATA;
  logic                  RD_PERR;
  logic                  RD_FERR;
  logic                  RX_RDY;
  logic                  FIFO_FULL;
  logic [DEPTH_LOG2:0]   LEVEL;
  logic                  OVERFLOW;
  logic                  THRESH_IRQ;
  logic                  TIMEOUT_IRQ;

  modport master (
    output BAUD_TICK, RX_STROBE, RX_DATA, RX_PERR, RX_FERR, RD_EN, CLR_ERR, RX_THRESH,
    input  RD_DATA, RD_PERR, RD_FERR, RX_RDY, FIFO_FULL, LEVEL, OVERFLOW, THRESH_IRQ,
           TIMEOUT_IRQ
  );

  modport slave (
    input  BAUD_TICK, RX_STROBE, RX_DATA, RX_PERR, RX_FERR, RD_EN, CLR_ERR, RX_THRESH,
    output RD_DATA, RD_PERR, RD_FERR, RX_RDY, FIFO_FULL, LEVEL, OVERFLOW, THRESH_IRQ,
           TIMEOUT_IRQ
  );
endinterface

// File: rtl/uart_rx_fifo_ctrl.sv
// UART receive FIFO controller.
// Buffers {FERR,PERR,DATA} entries from the RX engine, presents show-ahead head
// data to the CPU, tracks fill level, sticky overflow and a level-threshold irq.
// Optional character-timeout interrupt is built when macro UART_RX_TIMEOUT_EN
// is defined; otherwise TIMEOUT_IRQ is tied low.
module uart_rx_fifo_ctrl #(
  parameter int DEPTH_LOG2    = 4,
  parameter int TIMEOUT_TICKS = 640
) (
  input logic              CLK,
  input logic              RESET,
  uart_rx_fifo_ctrl_if.slave bus
);

  localparam int unsigned              DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]      FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]      LVL_ONE    = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0]    PTR_ONE    = DEPTH_LOG2'(1);

  logic [9:0]            mem_q [0:DEPTH-1];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  overflow_q, overflow_d;
  logic                  thresh_irq_q, thresh_irq_d;

  logic       full_s;
  logic       empty_s;
  logic       push_s;
  logic       pop_s;
  logic       drop_s;
  logic [9:0] head_s;

  // Decode occupancy, qualify push/pop/drop and compute next pointer/level/flag values.
  always_comb begin
    full_s       = (level_q == FULL_LEVEL);
    empty_s      = (level_q == '0);
    pop_s        = bus.RD_EN & ~empty_s;
    // A push into a full FIFO is still accepted when a pop frees a slot the same cycle.
    push_s       = bus.RX_STROBE & (~full_s | pop_s);
    drop_s       = bus.RX_STROBE & full_s & ~pop_s;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    overflow_d   = overflow_q;
    thresh_irq_d = 1'b0;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    // A new drop outranks a simultaneous clear so the loss is never hidden.
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (bus.CLR_ERR) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end

    // Registered compare against the current level: lags LEVEL by one cycle.
    if ((bus.RX_THRESH != '0) && (level_q >= bus.RX_THRESH)) begin
      thresh_irq_d = 1'b1;
    end else begin
      thresh_irq_d = 1'b0;
    end
  end

  // Control state register with synchronous reset; storage is left unreset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      overflow_q   <= 1'b0;
      thresh_irq_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      overflow_q   <= overflow_d;
      thresh_irq_q <= thresh_irq_d;
    end
  end

  // Entry storage write; a strobe in the reset cycle is ignored.
  always_ff @(posedge CLK) begin
    if (push_s && !RESET) begin
      mem_q[wr_ptr_q] <= {bus.RX_FERR, bus.RX_PERR, bus.RX_DATA};
    end
  end

  // Show-ahead head entry, forced to zero while the FIFO is empty.
  always_comb begin
    if (empty_s) begin
      head_s = 10'h000;
    end else begin
      head_s = mem_q[rd_ptr_q];
    end
  end

  assign bus.RD_DATA    = head_s[7:0];
  assign bus.RD_PERR    = head_s[8];
  assign bus.RD_FERR    = head_s[9];
  assign bus.RX_RDY     = ~empty_s;
  assign bus.FIFO_FULL  = full_s;
  assign bus.LEVEL      = level_q;
  assign bus.OVERFLOW   = overflow_q;
  assign bus.THRESH_IRQ = thresh_irq_q;

`ifdef UART_RX_TIMEOUT_EN
  typedef enum logic {
    TO_IDLE  = 1'b0,
    TO_COUNT = 1'b1
  } to_state_e;

  localparam logic [9:0] TO_LAST = 10'(TIMEOUT_TICKS - 1);

  to_state_e  to_state_q, to_state_d;
  logic [9:0] to_cnt_q, to_cnt_d;
  logic       to_irq_q, to_irq_d;
  logic       activity_s;
  logic       fire_s;

  // Timeout FSM: count baud ticks of inactivity while data waits in the FIFO.
  always_comb begin
    to_state_d = to_state_q;
    to_cnt_d   = to_cnt_q;
    fire_s     = 1'b0;
    activity_s = push_s | pop_s;

    case (to_state_q)
      TO_IDLE: begin
        to_cnt_d = 10'd0;
        if (level_q != '0) begin
          to_state_d = TO_COUNT;
        end else begin
          to_state_d = TO_IDLE;
        end
      end
      TO_COUNT: begin
        if (level_q == '0) begin
          to_state_d = TO_IDLE;
          to_cnt_d   = 10'd0;
        end else if (activity_s) begin
          to_cnt_d   = 10'd0;
        end else if (bus.BAUD_TICK) begin
          // Counter saturates at the firing value until activity restarts it.
          if (to_cnt_q == TO_LAST) begin
            fire_s   = 1'b1;
            to_cnt_d = to_cnt_q;
          end else begin
            to_cnt_d = to_cnt_q + 10'd1;
          end
        end else begin
          to_cnt_d = to_cnt_q;
        end
      end
      default: begin
        to_state_d = TO_IDLE;
        to_cnt_d   = 10'd0;
      end
    endcase

    // Any push or pop clears the irq, including one coinciding with the firing tick.
    if (activity_s) begin
      to_irq_d = 1'b0;
    end else if (fire_s) begin
      to_irq_d = 1'b1;
    end else begin
      to_irq_d = to_irq_q;
    end
  end

  // Timeout state, counter and sticky irq registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      to_state_q <= TO_IDLE;
      to_cnt_q   <= 10'd0;
      to_irq_q   <= 1'b0;
    end else begin
      to_state_q <= to_state_d;
      to_cnt_q   <= to_cnt_d;
      to_irq_q   <= to_irq_d;
    end
  end

  assign bus.TIMEOUT_IRQ = to_irq_q;
`else
  logic unused_baud_tick_s;
  assign unused_baud_tick_s = bus.BAUD_TICK;
  assign bus.TIMEOUT_IRQ    = 1'b0;
`endif

endmodule
